aes_add_round_key_stage: RTL and testbench

Registered AddRoundKey stage that sits directly downstream of the MixColumns stage in the AES-128 encryption datapath. It XORs each incoming 4×4 state matrix with the current round key, which it generates on the fly with an internal key schedule, and advances to the next round key after every accepted state. Input and output use valid/ready handshakes, so an upstream round controller can stream rounds 0 through 10 through it one state at a time.

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_add_round_key_stage_if.sv | 26 ++
 rtl/aes_key_step.sv | 42 ++++
 rtl/aes_add_round_key_stage.sv | 82 ++++++++
 tb/tb_aes_add_round_key_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES shared types, round-constant table and S-box lookup used by the
// datapath stages (AddRoundKey key schedule and SubBytes).
package aes_pkg;

    typedef logic [0:3][0:3][7:0] state_t;
    typedef logic [31:0]          word_t;

    localparam int AES128_NR = 10;

    // Entry 0 is never used; rounds 1..10 index directly.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_add_round_key_stage_if.sv
// Handshake and data bundle for the AddRoundKey stage: key load, input and output channels.
interface aes_add_round_key_stage_if;
    import aes_pkg::*;

    logic       key_load;
    state_t     key_in;
    logic       in_valid;
    logic       in_ready;
    state_t     state_in;
    logic       out_valid;
    logic       out_ready;
    state_t     state_out;
    logic [3:0] round_out;
    logic       last_out;

    modport slave (
        input  key_load, key_in, in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, round_out, last_out
    );

    modport master (
        output key_load, key_in, in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, round_out, last_out
    );

endinterface

// File: rtl/aes_key_step.sv
// Combinational AES-128 key expansion step: next round key from the current one.
// Zero latency; no handshake, purely a function of its inputs.
module aes_key_step
    import aes_pkg::*;
(
    input  state_t     i_rk,
    input  logic [3:0] i_rnd,
    output state_t     o_rk_next
);

    word_t      w_w0, w_w1, w_w2, w_w3;
    word_t      w_n0, w_n1, w_n2, w_n3;
    word_t      w_t;
    logic [7:0] w_rcon;

    always_comb begin
        w_w0 = {i_rk[0][0], i_rk[1][0], i_rk[2][0], i_rk[3][0]};
        w_w1 = {i_rk[0][1], i_rk[1][1], i_rk[2][1], i_rk[3][1]};
        w_w2 = {i_rk[0][2], i_rk[1][2], i_rk[2][2], i_rk[3][2]};
        w_w3 = {i_rk[0][3], i_rk[1][3], i_rk[2][3], i_rk[3][3]};

        // Round 10 has no successor; the caller reloads the cipher key instead.
        w_rcon = (i_rnd < 4'd10) ? RCON[i_rnd + 4'd1] : 8'h00;

        // RotWord then SubWord, rcon folded into the leading byte.
        w_t = {sbox(w_w3[23:16]) ^ w_rcon, sbox(w_w3[15:8]),
               sbox(w_w3[7:0]), sbox(w_w3[31:24])};

        w_n0 = w_w0 ^ w_t;
        w_n1 = w_w1 ^ w_n0;
        w_n2 = w_w2 ^ w_n1;
        w_n3 = w_w3 ^ w_n2;

        for (int r = 0; r < 4; r++) begin
            o_rk_next[r][0] = w_n0[31-8*r -: 8];
            o_rk_next[r][1] = w_n1[31-8*r -: 8];
            o_rk_next[r][2] = w_n2[31-8*r -: 8];
            o_rk_next[r][3] = w_n3[31-8*r -: 8];
        end
    end

endmodule

// File: rtl/aes_add_round_key_stage.sv
// Registered AddRoundKey with on-the-fly AES-128 key schedule; 1-cycle latency.
// Stalls input (in_ready low) while the output is held or during key_load.
module aes_add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic                        clk,
    input  logic                        rst_n,
    aes_add_round_key_stage_if.slave    bus
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t     r_key;
    state_t     r_rk;
    logic [3:0] r_rnd;
    logic       r_key_valid;
    logic       r_out_valid;
    state_t     r_state_out;
    logic [3:0] r_round_out;
    logic       r_last_out;

    logic       w_in_ready;
    logic       w_accept;
    state_t     w_rk_next;

    aes_key_step u_key_step (
        .i_rk      (r_rk),
        .i_rnd     (r_rnd),
        .o_rk_next (w_rk_next)
    );

    assign w_in_ready = r_key_valid && !bus.key_load && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key       <= '0;
            r_rk        <= '0;
            r_rnd       <= '0;
            r_key_valid <= 1'b0;
        end else if (bus.key_load) begin
            r_key       <= bus.key_in;
            r_rk        <= bus.key_in;
            r_rnd       <= '0;
            r_key_valid <= 1'b1;
        end else if (w_accept) begin
            // After the final round the schedule restarts from the stored key.
            if (r_rnd == LAST_RND) begin
                r_rk  <= r_key;
                r_rnd <= '0;
            end else begin
                r_rk  <= w_rk_next;
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_state_out <= '0;
            r_round_out <= '0;
            r_last_out  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_state_out <= bus.state_in ^ r_rk;
            r_round_out <= r_rnd;
            r_last_out  <= (r_rnd == LAST_RND);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_state_out;
    assign bus.round_out = r_round_out;
    assign bus.last_out  = r_last_out;

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Scoreboard bench for the AddRoundKey stage using the FIPS-197 key-expansion vectors.
module tb_aes_add_round_key_stage;
    import aes_pkg::*;

    localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_HEX     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R0_OUT_HEX = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    localparam logic [0:10][127:0] RK_HEX = {
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct packed {
        logic [127:0] hex;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_add_round_key_stage_if bus();

    aes_add_round_key_stage #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           m_rnd    = 0;
    bit           last_acc = 1'b0;
    logic [127:0] held;
    logic [127:0] d;

    function automatic state_t to_state(input logic [127:0] h);
        state_t s;
        for (int i = 0; i < 16; i++) s[i%4][i/4] = h[127-8*i -: 8];
        return s;
    endfunction

    function automatic logic [127:0] to_hex(input state_t s);
        logic [127:0] h;
        for (int i = 0; i < 16; i++) h[127-8*i -: 8] = s[i%4][i/4];
        return h;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus at the falling edge, scores any output
    // transfer and records any input accept, then returns at the rising edge.
    task automatic cycle(input bit vld, input logic [127:0] din, input bit kl, input bit ordy);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = vld;
        bus.state_in  = to_state(din);
        bus.key_load  = kl;
        bus.key_in    = to_state(CIPHER_KEY);
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            check_eq("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_state", to_hex(bus.state_out), e.hex);
                check_eq("sb_round", 128'(bus.round_out), 128'(e.rnd));
                check_eq("sb_last",  128'(bus.last_out),  128'(e.last));
            end
        end
        last_acc = vld && bus.in_ready;
        if (last_acc) begin
            e.hex  = din ^ RK_HEX[m_rnd];
            e.rnd  = m_rnd[3:0];
            e.last = (m_rnd == 10);
            sb_q.push_back(e);
            m_rnd  = (m_rnd == 10) ? 0 : m_rnd + 1;
        end
        if (kl) m_rnd = 0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.key_load  = 1'b0;
        bus.key_in    = '0;
        bus.in_valid  = 1'b0;
        bus.state_in  = '0;
        bus.out_ready = 1'b0;
        #12;
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("rst_in_ready",  128'(bus.in_ready),  128'd0);
        check_eq("rst_state_out", to_hex(bus.state_out), 128'd0);
        check_eq("rst_round_out", 128'(bus.round_out), 128'd0);
        check_eq("rst_last_out",  128'(bus.last_out),  128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No key loaded yet: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, PT_HEX, 1'b0, 1'b1);
            check_eq("nokey_accept", 128'(last_acc), 128'd0);
        end

        // Round-0 key addition with the FIPS-197 example.
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, PT_HEX, 1'b0, 1'b1);
        check_eq("r0_accept", 128'(last_acc), 128'd1);
        #1;
        check_eq("r0_lat_valid", 128'(bus.out_valid), 128'd1);
        check_eq("r0_state", to_hex(bus.state_out), R0_OUT_HEX);
        check_eq("r0_round", 128'(bus.round_out), 128'd0);

        // Reload while an output drains, then walk the full schedule plus wrap.
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, '0, 1'b0, 1'b1);
            if (i == 10) begin
                #1;
                check_eq("r10_state", to_hex(bus.state_out), RK_HEX[10]);
                check_eq("r10_last",  128'(bus.last_out), 128'd1);
            end
        end
        #1;
        check_eq("wrap_state", to_hex(bus.state_out), CIPHER_KEY);
        check_eq("wrap_round", 128'(bus.round_out), 128'd0);
        check_eq("wrap_last",  128'(bus.last_out), 128'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: output held, no accepts, no round skipped.
        d = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, d, 1'b0, 1'b1);
        #1;
        held = to_hex(bus.state_out);
        for (int i = 0; i < 5; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b1, d, 1'b0, 1'b0);
            check_eq("bp_no_accept", 128'(last_acc), 128'd0);
            #1;
            check_eq("bp_valid_held", 128'(bus.out_valid), 128'd1);
            check_eq("bp_state_held", to_hex(bus.state_out), held);
        end
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b1, d, 1'b0, 1'b1);
        end

        // key_load wins over a valid input and restarts at round 0.
        d = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, d, 1'b1, 1'b1);
        check_eq("kl_no_accept", 128'(last_acc), 128'd0);
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b1, d, 1'b0, 1'b1);
        end

        // Asynchronous reset mid-stream clears outputs and the loaded key.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("arst_state_out", to_hex(bus.state_out), 128'd0);
        check_eq("arst_round_out", 128'(bus.round_out), 128'd0);
        check_eq("arst_last_out",  128'(bus.last_out), 128'd0);
        check_eq("arst_in_ready",  128'(bus.in_ready), 128'd0);
        sb_q.delete();
        m_rnd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, PT_HEX, 1'b0, 1'b1);
        check_eq("arst_need_key", 128'(last_acc), 128'd0);

        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_eq("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
